// File: rtl/psum_out_collector_pkg.sv
// Shared constants for the psum-out path: collector FSM encodings and the
// flat PE index helper also used by psum_sel_ctrl.
package psum_out_collector_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    function automatic int flat_idx(input int row, input int col, input int num_cols);
        return row * num_cols + col;
    endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Per-column synchronous FIFO holding psums between the PE handshake and the
// GLB write stage. Push on full and pop on empty are ignored.
module psum_col_fifo #(
    parameter int DATA_BITWIDTH = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [DATA_BITWIDTH-1:0] i_data,
    input  logic                     i_pop,
    output logic [DATA_BITWIDTH-1:0] o_data,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [DATA_BITWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITWIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     do_push_s, do_pop_s;

    assign o_full  = (count_q == CW'(FIFO_DEPTH));
    assign o_empty = (count_q == {CW{1'b0}});
    assign o_data  = mem_q[rd_ptr_q];

    // next-state for storage, pointers and occupancy
    always_comb begin
        do_push_s = i_push & ~o_full;
        do_pop_s  = i_pop & ~o_empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end

    // state registers; reset flushes the FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/psum_out_collector.sv
// Drains finished psums from the selected PE row of each column into
// per-column FIFOs and writes them round-robin to the GLB psum bank.
module psum_out_collector
    import psum_out_collector_pkg::*;
#(
    parameter int NUM_ROWS          = 3,
    parameter int NUM_COLS          = 3,
    parameter int DATA_BITWIDTH     = 16,
    parameter int FIFO_DEPTH        = 4,
    parameter int GLB_ADDR_BITWIDTH = 10
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic                                       i_start,
    input  logic [GLB_ADDR_BITWIDTH-1:0]               i_base_addr,
    input  logic [GLB_ADDR_BITWIDTH-1:0]               i_num_psum,
    input  logic [NUM_ROWS*NUM_COLS-1:0]               i_psum_out_sel,
    input  logic [NUM_ROWS*NUM_COLS-1:0]               i_pe_psum_valid,
    input  logic [NUM_ROWS*NUM_COLS*DATA_BITWIDTH-1:0] i_pe_psum_data,
    output logic [NUM_ROWS*NUM_COLS-1:0]               o_pe_psum_ready,
    output logic                                       o_glb_wr_en,
    output logic [GLB_ADDR_BITWIDTH-1:0]               o_glb_wr_addr,
    output logic [DATA_BITWIDTH-1:0]                   o_glb_wr_data,
    input  logic                                       i_glb_wr_ready,
    output logic                                       o_busy,
    output logic                                       o_done
);

    localparam int NPE  = NUM_ROWS * NUM_COLS;
    localparam int DW   = DATA_BITWIDTH;
    localparam int AW   = GLB_ADDR_BITWIDTH;
    localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CWID = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   base_q, base_d, num_q, num_d;
    logic [NPE-1:0]  sel_q, sel_d;
    logic [AW-1:0]   rcnt_q [NUM_COLS];
    logic [AW-1:0]   rcnt_d [NUM_COLS];
    logic [AW-1:0]   wcnt_q [NUM_COLS];
    logic [AW-1:0]   wcnt_d [NUM_COLS];
    logic [CWID-1:0] rr_ptr_q, rr_ptr_d, out_col_q, out_col_d;
    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   out_addr_q, out_addr_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic [RW-1:0]       src_row_s [NUM_COLS];
    logic [DW-1:0]       push_data_s [NUM_COLS];
    logic [DW-1:0]       fifo_dout_s [NUM_COLS];
    logic [NUM_COLS-1:0] col_en_s, fifo_full_s, fifo_empty_s, push_s, pop_s;
    logic [NPE-1:0]      pe_ready_s;
    logic                collect_s, clear_s, found_s, load_s, accept_s, all_wr_done_s;
    logic [CWID-1:0]     gnt_s, cand_s;
    logic [AW-1:0]       wr_idx_s;

    assign o_pe_psum_ready = pe_ready_s;
    assign o_glb_wr_en     = out_valid_q;
    assign o_glb_wr_addr   = out_addr_q;
    assign o_glb_wr_data   = out_data_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

    // source row per column: lowest row with its out-select flag set
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            src_row_s[c] = '0;
            col_en_s[c]  = 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (sel_q[flat_idx(r, c, NUM_COLS)] && !col_en_s[c]) begin
                    src_row_s[c] = RW'(r);
                    col_en_s[c]  = 1'b1;
                end else begin
                    col_en_s[c] = col_en_s[c];
                end
            end
        end
    end

    // PE ready and FIFO push; only the source PE of a column can transfer
    always_comb begin
        collect_s = (state_q == ST_COLLECT);
        for (int c = 0; c < NUM_COLS; c++) begin
            push_s[c]      = 1'b0;
            push_data_s[c] = '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                pe_ready_s[flat_idx(r, c, NUM_COLS)] = collect_s & col_en_s[c]
                    & (src_row_s[c] == RW'(r)) & ~fifo_full_s[c] & (rcnt_q[c] < num_q);
                push_s[c] = push_s[c] | (i_pe_psum_valid[flat_idx(r, c, NUM_COLS)]
                    & pe_ready_s[flat_idx(r, c, NUM_COLS)]);
                push_data_s[c] = push_data_s[c]
                    | (i_pe_psum_data[flat_idx(r, c, NUM_COLS)*DW +: DW]
                       & {DW{i_pe_psum_valid[flat_idx(r, c, NUM_COLS)]
                             & pe_ready_s[flat_idx(r, c, NUM_COLS)]}});
            end
        end
    end

    // round-robin grant starting at rr_ptr_q, loads the output stage
    always_comb begin
        found_s = 1'b0;
        gnt_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            cand_s = CWID'((32'(rr_ptr_q) + 32'(k)) % 32'(NUM_COLS));
            if (!found_s && !fifo_empty_s[cand_s]) begin
                found_s = 1'b1;
                gnt_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        accept_s      = out_valid_q & i_glb_wr_ready;
        load_s        = collect_s & found_s & (~out_valid_q | i_glb_wr_ready);
        pop_s         = '0;
        pop_s[gnt_s]  = load_s;
        // the held word of the same column is being accepted this cycle
        wr_idx_s      = wcnt_q[gnt_s] + AW'(accept_s && (out_col_q == gnt_s));
    end

    // per-column counters, completion detect and GLB output stage
    always_comb begin
        all_wr_done_s = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
            rcnt_d[c] = clear_s ? '0 : rcnt_q[c] + AW'(push_s[c]);
            wcnt_d[c] = clear_s ? '0 : wcnt_q[c] + AW'(accept_s && (out_col_q == CWID'(c)));
            if (col_en_s[c] && (wcnt_q[c] != num_q)) begin
                all_wr_done_s = 1'b0;
            end else begin
                all_wr_done_s = all_wr_done_s;
            end
        end
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_col_d   = out_col_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_addr_d  = base_q + AW'(gnt_s) * num_q + wr_idx_s;
            out_data_d  = fifo_dout_s[gnt_s];
            out_col_d   = gnt_s;
            rr_ptr_d    = (gnt_s == CWID'(NUM_COLS - 1)) ? '0 : gnt_s + CWID'(1);
        end else if (accept_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // pass FSM with pass parameters captured at start
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        sel_d   = sel_q;
        clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    base_d  = i_base_addr;
                    num_d   = i_num_psum;
                    sel_d   = i_psum_out_sel;
                    clear_s = 1'b1;
                    state_d = (i_num_psum == {AW{1'b0}}) ? ST_DONE : ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (all_wr_done_s && !out_valid_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            sel_q       <= '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                rcnt_q[c] <= '0;
                wcnt_q[c] <= '0;
            end
            rr_ptr_q    <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            sel_q       <= sel_d;
            rcnt_q      <= rcnt_d;
            wcnt_q      <= wcnt_d;
            rr_ptr_q    <= rr_ptr_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col_fifo
        psum_col_fifo #(
            .DATA_BITWIDTH (DW),
            .FIFO_DEPTH    (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_push  (push_s[c]),
            .i_data  (push_data_s[c]),
            .i_pop   (pop_s[c]),
            .o_data  (fifo_dout_s[c]),
            .o_full  (fifo_full_s[c]),
            .o_empty (fifo_empty_s[c])
        );
    end

endmodule

// File: tb/tb_psum_out_collector.sv
// Directed bench for psum_out_collector; PEs emit {row,col,index} words so
// every GLB write can be matched to its address.
module tb_psum_out_collector;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_start;
    logic [9:0]   i_base_addr;
    logic [9:0]   i_num_psum;
    logic [8:0]   i_psum_out_sel;
    logic [8:0]   i_pe_psum_valid;
    logic [143:0] i_pe_psum_data;
    logic [8:0]   o_pe_psum_ready;
    logic         o_glb_wr_en;
    logic [9:0]   o_glb_wr_addr;
    logic [15:0]  o_glb_wr_data;
    logic         i_glb_wr_ready;
    logic         o_busy;
    logic         o_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sent [9];
    logic        tb_clear;
    logic [9:0]  wr_addr_log [$];
    logic [15:0] wr_data_log [$];
    int          done_cnt, done_cyc, stall_bad;
    bit          timed_out;
    logic [8:0]  ready_or, ready_stall_end;
    logic        busy_after;

    psum_out_collector dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_start         (i_start),
        .i_base_addr     (i_base_addr),
        .i_num_psum      (i_num_psum),
        .i_psum_out_sel  (i_psum_out_sel),
        .i_pe_psum_valid (i_pe_psum_valid),
        .i_pe_psum_data  (i_pe_psum_data),
        .o_pe_psum_ready (o_pe_psum_ready),
        .o_glb_wr_en     (o_glb_wr_en),
        .o_glb_wr_addr   (o_glb_wr_addr),
        .o_glb_wr_data   (o_glb_wr_data),
        .i_glb_wr_ready  (i_glb_wr_ready),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            i_pe_psum_data[k*16 +: 16] = {4'(k / 3), 4'(k % 3), sent[k]};
        end
    end

    always @(posedge i_clk) begin
        for (int k = 0; k < 9; k++) begin
            if (tb_clear) sent[k] <= 8'd0;
            else if (i_pe_psum_valid[k] && o_pe_psum_ready[k]) sent[k] <= sent[k] + 8'd1;
        end
    end

    function automatic logic [15:0] exp_data(input logic [9:0] off, input logic [9:0] num,
                                             input logic [5:0] rowmap);
        int c, idx;
        c   = int'(off) / int'(num);
        idx = int'(off) % int'(num);
        return {4'(rowmap[c*2 +: 2]), 4'(c), 8'(idx)};
    endfunction

    task automatic run_pass(input logic [9:0] base, input logic [9:0] num, input logic [8:0] sel,
                            input int stall_at, input int stall_len);
        logic       prev_stall;
        logic [9:0] pa;
        logic [15:0] pd;
        int         cyc;
        bit         fin;
        wr_addr_log.delete();
        wr_data_log.delete();
        done_cnt = 0; done_cyc = -1; stall_bad = 0;
        ready_or = 9'd0; ready_stall_end = 9'h1FF; busy_after = 1'b1;
        @(negedge i_clk); tb_clear = 1'b1;
        @(negedge i_clk); tb_clear = 1'b0;
        i_base_addr = base; i_num_psum = num; i_psum_out_sel = sel; i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        cyc = 0; fin = 0; prev_stall = 1'b0; pa = 10'd0; pd = 16'd0;
        while (!fin && cyc < 400) begin
            i_glb_wr_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            ready_or = ready_or | o_pe_psum_ready;
            if (cyc == stall_at + stall_len - 1) ready_stall_end = o_pe_psum_ready;
            if (prev_stall && o_glb_wr_en && (o_glb_wr_addr !== pa || o_glb_wr_data !== pd))
                stall_bad++;
            prev_stall = o_glb_wr_en && !i_glb_wr_ready;
            pa = o_glb_wr_addr; pd = o_glb_wr_data;
            if (o_glb_wr_en && i_glb_wr_ready) begin
                wr_addr_log.push_back(o_glb_wr_addr);
                wr_data_log.push_back(o_glb_wr_data);
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc) begin
                busy_after = o_busy;
                fin = 1;
            end
            @(negedge i_clk);
            cyc++;
        end
        timed_out = !fin;
        i_glb_wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({o_busy, o_done, o_glb_wr_en} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {o_busy, o_done, o_glb_wr_en});
        end
        checks++;
        if (o_pe_psum_ready !== 9'd0 || o_glb_wr_addr !== 10'd0 || o_glb_wr_data !== 16'd0) begin
            errors++; $display("FAIL reset_data: ready %h addr %h data %h expected 0",
                               o_pe_psum_ready, o_glb_wr_addr, o_glb_wr_data);
        end
    endtask

    task automatic test_row0_all_cols();
        logic [9:0] off;
        bit [15:0]  got;
        got = 16'd0;
        run_pass(10'h100, 10'd2, 9'b000000111, 1000, 0);
        checks++;
        if (timed_out || done_cnt != 1) begin
            errors++; $display("FAIL row0_done: timeout %0d pulses %0d expected 0/1", timed_out, done_cnt);
        end
        checks++;
        if (wr_addr_log.size() != 6) begin
            errors++; $display("FAIL row0_count: got %0d expected 6", wr_addr_log.size());
        end
        for (int i = 0; i < wr_addr_log.size(); i++) begin
            off = wr_addr_log[i] - 10'h100;
            checks++;
            if (off >= 10'd6 || got[off[3:0]]) begin
                errors++; $display("FAIL row0_addr: got %h expected unique 100..105", wr_addr_log[i]);
            end else if (wr_data_log[i] !== exp_data(off, 10'd2, 6'b000000)) begin
                errors++; $display("FAIL row0_data: addr %h got %h expected %h", wr_addr_log[i],
                                   wr_data_log[i], exp_data(off, 10'd2, 6'b000000));
            end else begin
                got[off[3:0]] = 1'b1;
            end
        end
        checks++;
        if (busy_after !== 1'b0 || ready_or !== 9'b000000111) begin
            errors++; $display("FAIL row0_busy_ready: busy %b ready %b expected 0 000000111", busy_after, ready_or);
        end
    endtask

    task automatic test_sparse_sel();
        logic [9:0] off;
        bit [15:0]  got;
        got = 16'd0;
        run_pass(10'h020, 10'd3, 9'b010000011, 1000, 0);
        checks++;
        if (timed_out || done_cnt != 1 || wr_addr_log.size() != 6) begin
            errors++; $display("FAIL sparse_pass: timeout %0d pulses %0d writes %0d expected 0/1/6",
                               timed_out, done_cnt, wr_addr_log.size());
        end
        checks++;
        if (ready_or !== 9'b000000011) begin
            errors++; $display("FAIL sparse_ready: got %b expected 000000011", ready_or);
        end
        for (int i = 0; i < wr_addr_log.size(); i++) begin
            off = wr_addr_log[i] - 10'h020;
            checks++;
            if (off >= 10'd6 || got[off[3:0]]) begin
                errors++; $display("FAIL sparse_addr: got %h expected unique 020..025", wr_addr_log[i]);
            end else if (wr_data_log[i] !== exp_data(off, 10'd3, 6'b000000)) begin
                errors++; $display("FAIL sparse_data: addr %h got %h expected %h", wr_addr_log[i],
                                   wr_data_log[i], exp_data(off, 10'd3, 6'b000000));
            end else begin
                got[off[3:0]] = 1'b1;
            end
        end
    endtask

    task automatic test_stall();
        logic [9:0] off;
        bit [15:0]  got;
        got = 16'd0;
        run_pass(10'h040, 10'd8, 9'b010001000, 3, 5);
        checks++;
        if (timed_out || done_cnt != 1 || wr_addr_log.size() != 16) begin
            errors++; $display("FAIL stall_pass: timeout %0d pulses %0d writes %0d expected 0/1/16",
                               timed_out, done_cnt, wr_addr_log.size());
        end
        checks++;
        if (stall_bad != 0) begin
            errors++; $display("FAIL stall_stable: got %0d changes expected 0", stall_bad);
        end
        checks++;
        if (ready_stall_end !== 9'd0 || ready_or !== 9'b010001000) begin
            errors++; $display("FAIL stall_ready: end %b seen %b expected 0 010001000",
                               ready_stall_end, ready_or);
        end
        for (int i = 0; i < wr_addr_log.size(); i++) begin
            off = wr_addr_log[i] - 10'h040;
            checks++;
            if (off >= 10'd16 || got[off[3:0]]) begin
                errors++; $display("FAIL stall_addr: got %h expected unique 040..04f", wr_addr_log[i]);
            end else if (wr_data_log[i] !== exp_data(off, 10'd8, 6'b001001)) begin
                errors++; $display("FAIL stall_data: addr %h got %h expected %h", wr_addr_log[i],
                                   wr_data_log[i], exp_data(off, 10'd8, 6'b001001));
            end else begin
                got[off[3:0]] = 1'b1;
            end
        end
    endtask

    task automatic test_zero_psum();
        run_pass(10'h000, 10'd0, 9'b000000111, 1000, 0);
        checks++;
        if (timed_out || done_cyc != 0 || done_cnt != 1) begin
            errors++; $display("FAIL zero_done: timeout %0d cycle %0d pulses %0d expected 0/0/1",
                               timed_out, done_cyc, done_cnt);
        end
        checks++;
        if (wr_addr_log.size() != 0 || ready_or !== 9'd0 || busy_after !== 1'b0) begin
            errors++; $display("FAIL zero_idle: writes %0d ready %b busy %b expected 0/0/0",
                               wr_addr_log.size(), ready_or, busy_after);
        end
    endtask

    task automatic test_addr_wrap();
        logic [9:0] exp_addr [4];
        logic [9:0] off;
        bit [15:0]  got;
        got = 16'd0;
        exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
        run_pass(10'h3FE, 10'd2, 9'b000000011, 1000, 0);
        checks++;
        if (timed_out || done_cnt != 1 || wr_addr_log.size() != 4) begin
            errors++; $display("FAIL wrap_pass: timeout %0d pulses %0d writes %0d expected 0/1/4",
                               timed_out, done_cnt, wr_addr_log.size());
        end
        for (int i = 0; i < wr_addr_log.size(); i++) begin
            off = wr_addr_log[i] - 10'h3FE;
            checks++;
            if (off >= 10'd4 || got[off[3:0]] || wr_addr_log[i] !== exp_addr[off[1:0]]) begin
                errors++; $display("FAIL wrap_addr: got %h expected unique of 3fe,3ff,000,001", wr_addr_log[i]);
            end else if (wr_data_log[i] !== exp_data(off, 10'd2, 6'b000000)) begin
                errors++; $display("FAIL wrap_data: addr %h got %h expected %h", wr_addr_log[i],
                                   wr_data_log[i], exp_data(off, 10'd2, 6'b000000));
            end else begin
                got[off[3:0]] = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        int dones;
        @(negedge i_clk); tb_clear = 1'b1;
        @(negedge i_clk); tb_clear = 1'b0;
        i_base_addr = 10'h000; i_num_psum = 10'd4; i_psum_out_sel = 9'b000000111; i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL midrst_busy_before: got %b expected 1", o_busy);
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_glb_wr_en} !== 3'b000 || o_pe_psum_ready !== 9'd0
            || o_glb_wr_addr !== 10'd0 || o_glb_wr_data !== 16'd0) begin
            errors++; $display("FAIL midrst_outputs: ctrl %b ready %h addr %h data %h expected 0",
                               {o_busy, o_done, o_glb_wr_en}, o_pe_psum_ready, o_glb_wr_addr, o_glb_wr_data);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            if (o_done || o_busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", dones);
        end
        run_pass(10'h200, 10'd2, 9'b000000111, 1000, 0);
        checks++;
        if (timed_out || done_cnt != 1 || wr_addr_log.size() != 6) begin
            errors++; $display("FAIL midrst_clean_pass: timeout %0d pulses %0d writes %0d expected 0/1/6",
                               timed_out, done_cnt, wr_addr_log.size());
        end
        for (int i = 0; i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_data_log[i] !== exp_data(wr_addr_log[i] - 10'h200, 10'd2, 6'b000000)) begin
                errors++; $display("FAIL midrst_data: addr %h got %h", wr_addr_log[i], wr_data_log[i]);
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0; tb_clear = 1'b1; i_start = 1'b0;
        i_base_addr = 10'd0; i_num_psum = 10'd0; i_psum_out_sel = 9'd0;
        i_pe_psum_valid = 9'h1FF; i_glb_wr_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        test_reset();
        i_rst_n = 1'b1;
        tb_clear = 1'b0;
        test_row0_all_cols();
        test_sparse_sel();
        test_stall();
        test_zero_psum();
        test_addr_wrap();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_out_collector.md
Name: psum_out_collector

Overview:
- Drains finished partial sums from the PE array once accumulation reaches the row whose psum_out_sel is asserted.
- Buffers them per column and writes them to the global buffer (GLB) psum bank through a valid/ready write port.
- Consumes the o_psum_out_sel vector produced by psum_sel_ctrl; this block is the receiving end of the psum-out path.

Parameters:
- NUM_ROWS, 3, PE array rows
- NUM_COLS, 3, PE array columns
- DATA_BITWIDTH, 16, psum word width
- FIFO_DEPTH, 4, per-column buffer entries (power of two, >=2)
- GLB_ADDR_BITWIDTH, 10, GLB psum address width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; begin a collection pass
- i_base_addr  in  GLB_ADDR_BITWIDTH  GLB start address of the pass
- i_num_psum  in  GLB_ADDR_BITWIDTH  psums expected per enabled column
- i_psum_out_sel  in  NUM_ROWS*NUM_COLS  out-select flags, index row*NUM_COLS+col
- i_pe_psum_valid  in  NUM_ROWS*NUM_COLS  PE psum-out valid
- i_pe_psum_data  in  NUM_ROWS*NUM_COLS*DATA_BITWIDTH  PE psum-out data, same indexing
- o_pe_psum_ready  out  NUM_ROWS*NUM_COLS  PE psum-out ready
- o_glb_wr_en  out  1  GLB write valid
- o_glb_wr_addr  out  GLB_ADDR_BITWIDTH  GLB write address
- o_glb_wr_data  out  DATA_BITWIDTH  GLB write data
- i_glb_wr_ready  in  1  GLB accepts write
- o_busy  out  1  pass in progress
- o_done  out  1  one-cycle pulse at pass completion

Behaviour:
- Reset: i_clk and i_rst_n as stated; reset is asynchronous, active-low. All outputs 0, FIFOs empty, counters 0, state IDLE.
- States:
  - IDLE: on i_start go to COLLECT. Capture i_base_addr, i_num_psum and i_psum_out_sel into registers.
  - COLLECT: run until every enabled column has written i_num_psum words, then go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
  - i_num_psum==0 at start: IDLE -> DONE directly.
- Column source selection:
  - The source of column c is the lowest row r with captured out_sel[r*NUM_COLS+c]=1.
  - A column with no set bit is disabled and counts as complete.
  - Selection is frozen for the whole pass.
- PE handshake:
  - o_pe_psum_ready[r*NUM_COLS+c] = (state==COLLECT) & (r is source of c) & FIFO c not full & column c received count < num_psum.
  - Transfer when valid&ready; push the word into FIFO c.
  - Non-source PEs always see ready=0.
- FIFO rules:
  - Simultaneous push and pop on a full FIFO is not allowed; ready already excludes full.
  - Push and pop in the same cycle on a non-empty, non-full FIFO is allowed and keeps the count.
- GLB write:
  - Registered output stage. o_glb_wr_en, addr and data stay stable while o_glb_wr_en=1 and i_glb_wr_ready=0.
  - A new word is loaded when the stage is empty or its word is accepted in the same cycle. Sustained throughput is 1 word/cycle.
- Arbitration:
  - Round-robin over non-empty FIFOs, starting after the last-granted column; pointer starts at column 0 after reset.
- Address:
  - base + c*num_psum + wcnt[c], where wcnt[c] counts accepted writes of column c.
  - Arithmetic is modulo 2^GLB_ADDR_BITWIDTH; wrap-around is silent, with no error flag.
- Pass completion: the pass completes when the last write is accepted (wcnt==num_psum for all enabled columns) and the output stage is empty.
- o_busy = 1 in COLLECT and DONE.
- i_start while not IDLE is ignored.
- Reset asserted mid-pass aborts immediately: FIFOs are flushed and no o_done is issued.
- Latency: PE transfer at cycle t puts o_glb_wr_en=1 at t+2 at the earliest (FIFO write, then output register).

Decomposition:
- Shared header of localparams: state encodings (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2) and a flat-vector index helper (row*NUM_COLS+col) shared with psum_sel_ctrl.
- Sub-module psum_col_fifo: synchronous FIFO, one instance per column, with i_push/i_pop/o_full/o_empty/o_data. Same clock and reset.
- Top level contains the FSM, source select, arbiter, counters and output register.

Test Plan:
- 3x3 array, out_sel only row 0 in all columns, num_psum=2, base=0x100, PEs always valid, GLB ready=1 -> 6 writes to 0x100,0x101,0x102,0x103,0x104,0x105 with data matching each column's order. o_done pulses once, then o_busy=0.
- out_sel rows 0 and 2 set in column 1, column 2 has no bits set -> only row 0 of columns 0 and 1 get ready. Column 2 issues no writes. Pass completes after 2*num_psum writes.
- GLB ready held 0 for 5 cycles mid-pass -> addr/data stable across the stall. FIFOs fill to FIFO_DEPTH, then PE ready drops. No word is lost or duplicated.
- num_psum=0 with i_start -> o_done in the cycle after start. No ready asserted, no writes.
- base=0x3FE, num_psum=2, 2 columns enabled -> addresses 0x3FE,0x3FF,0x000,0x001.
- i_rst_n pulsed low during COLLECT -> all outputs 0 asynchronously and no o_done. A following i_start runs a clean pass.
